// File: rtl/mpu_pkg.sv
// Shared constants, opcodes and state encoding for the MPU command front-end.
package mpu_pkg;

    localparam int ELEMENT_W    = 8;
    localparam int ELEMENTS     = 25;
    localparam int MATRIX_W     = ELEMENT_W * ELEMENTS;
    localparam int EXEC_LATENCY = 3;
    localparam int IDX_W        = $clog2(ELEMENTS);
    localparam int LSB_W        = $clog2(MATRIX_W);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_CONFIG = 3'd2;
    localparam logic [2:0] OP_EXEC   = 3'd3;
    localparam logic [2:0] OP_READ   = 3'd4;

    localparam logic [2:0] SEL_ADD       = 3'd0;
    localparam logic [2:0] SEL_SUB       = 3'd1;
    localparam logic [2:0] SEL_SCALE     = 3'd2;
    localparam logic [2:0] SEL_TRANSPOSE = 3'd3;
    localparam logic [2:0] SEL_DET       = 3'd4;
    localparam logic [2:0] SEL_IDENTITY  = 3'd5;
    localparam logic [2:0] SEL_MUL       = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC_WAIT,
        ST_STREAM
    } state_t;

    // Bit offset of element idx inside a flat matrix vector.
    function automatic logic [LSB_W-1:0] elem_lsb(input logic [IDX_W-1:0] idx);
        return LSB_W'(idx) * LSB_W'(ELEMENT_W);
    endfunction

endpackage

// File: rtl/mpu_result_streamer.sv
// Holds the captured result matrix and streams it out one element per handshake.
module mpu_result_streamer
    import mpu_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 capture,
    input  logic [MATRIX_W-1:0]  result,
    input  logic                 start,
    output logic                 done,
    output logic [ELEMENT_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [MATRIX_W-1:0] buffer;
    logic [IDX_W-1:0]    idx;
    logic                active;
    logic                fire;
    logic                last;

    assign fire      = active && out_ready;
    assign last      = (idx == IDX_W'(ELEMENTS - 1));
    assign done      = fire && last;
    assign out_valid = active;
    assign out_data  = buffer[elem_lsb(idx) +: ELEMENT_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            buffer <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else begin
            if (capture) begin
                buffer <= result;
            end
            if (start) begin
                idx    <= '0;
                active <= 1'b1;
            end else if (fire) begin
                // idx parks at zero after the final element so the next READ starts clean
                idx    <= last ? '0 : idx + 1'b1;
                active <= !last;
            end
        end
    end

endmodule

// File: rtl/mpu_command_unit.sv
// Host command front-end for the matrix operation unit: decodes LOAD/CONFIG/EXEC/READ.
// Optional MPU_CMD_ERROR_EN adds a sticky error flag for illegal opcodes and bad LOAD indices.
module mpu_command_unit
    import mpu_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic [MATRIX_W-1:0]  matrix_a,
    output logic [MATRIX_W-1:0]  matrix_b,
    output logic [2:0]           operation,
    output logic [7:0]           size,
    output logic [7:0]           factor,
    input  logic [MATRIX_W-1:0]  result,
    output logic [ELEMENT_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef MPU_CMD_ERROR_EN
    output logic                 error,
`endif
    output logic                 busy
);

    localparam int CNT_W = $clog2(EXEC_LATENCY + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       opcode;
    logic [IDX_W-1:0] load_idx;
    logic             load_in_range;
    logic             wr_a;
    logic             wr_b;
    logic             wr_cfg;
    logic             load_cnt;
    logic             capture;
    logic             stream_start;
    logic             stream_done;
    logic             bad_cmd;
    logic             err_clr;
    logic             unused_instr;

    assign opcode        = instr[31:29];
    assign load_idx      = instr[27:23];
    assign load_in_range = (load_idx < IDX_W'(ELEMENTS));
    assign instr_ready   = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign unused_instr  = ^instr[22:19];

    always_comb begin
        state_next   = state;
        wr_a         = 1'b0;
        wr_b         = 1'b0;
        wr_cfg       = 1'b0;
        load_cnt     = 1'b0;
        capture      = 1'b0;
        stream_start = 1'b0;
        bad_cmd      = 1'b0;
        err_clr      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    case (opcode)
                        OP_NOP:    err_clr = instr[0];
                        OP_LOAD: begin
                            if (load_in_range) begin
                                wr_a = !instr[28];
                                wr_b = instr[28];
                            end else begin
                                bad_cmd = 1'b1;
                            end
                        end
                        OP_CONFIG: wr_cfg = 1'b1;
                        OP_EXEC: begin
                            load_cnt   = 1'b1;
                            state_next = ST_EXEC_WAIT;
                        end
                        OP_READ: begin
                            stream_start = 1'b1;
                            state_next   = ST_STREAM;
                        end
                        default:   bad_cmd = 1'b1;
                    endcase
                end
            end
            ST_EXEC_WAIT: begin
                if (wait_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (stream_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (load_cnt) begin
                wait_cnt <= CNT_W'(EXEC_LATENCY - 1);
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // Operand and config registers only change from IDLE, so they hold through a run.
    always_ff @(posedge clock) begin
        if (reset) begin
            matrix_a  <= '0;
            matrix_b  <= '0;
            operation <= '0;
            size      <= '0;
            factor    <= '0;
        end else begin
            if (wr_a) begin
                matrix_a[elem_lsb(load_idx) +: ELEMENT_W] <= instr[7:0];
            end
            if (wr_b) begin
                matrix_b[elem_lsb(load_idx) +: ELEMENT_W] <= instr[7:0];
            end
            if (wr_cfg) begin
                operation <= instr[18:16];
                size      <= instr[15:8];
                factor    <= instr[7:0];
            end
        end
    end

`ifdef MPU_CMD_ERROR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            error <= 1'b0;
        end else if (bad_cmd) begin
            error <= 1'b1;
        end else if (err_clr) begin
            error <= 1'b0;
        end
    end
`else
    logic unused_err;
    assign unused_err = bad_cmd | err_clr;
`endif

    mpu_result_streamer u_streamer (
        .clock     (clock),
        .reset     (reset),
        .capture   (capture),
        .result    (result),
        .start     (stream_start),
        .done      (stream_done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_mpu_command_unit.sv
// Randomized bench for mpu_command_unit against an array-based behavioural model.
module tb_mpu_command_unit;

    localparam int N_EL = 25;
    localparam int LAT  = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         instr_ready;
    logic [199:0] matrix_a;
    logic [199:0] matrix_b;
    logic [2:0]   operation;
    logic [7:0]   size;
    logic [7:0]   factor;
    logic [199:0] result;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
`ifdef MPU_CMD_ERROR_EN
    logic         error;
`endif

    always #5 clock = ~clock;

    mpu_command_unit dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .matrix_a    (matrix_a),
        .matrix_b    (matrix_b),
        .operation   (operation),
        .size        (size),
        .factor      (factor),
        .result      (result),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef MPU_CMD_ERROR_EN
        .error       (error),
`endif
        .busy        (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] ma [N_EL];
    logic [7:0] mb [N_EL];
    logic [7:0] mbuf [N_EL];
    logic [2:0] mop;
    logic [7:0] msize;
    logic [7:0] mfactor;
    logic       merr;
    logic [7:0] first_el;
    logic [7:0] last_el;

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [199:0] pack(input logic [7:0] arr [N_EL]);
        logic [199:0] m;
        for (int i = 0; i < N_EL; i++) m[i*8 +: 8] = arr[i];
        return m;
    endfunction

    function automatic logic [199:0] rand200();
        logic [199:0] r;
        for (int i = 0; i < N_EL; i++) r[i*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    // Stand-in for the operation unit: any deterministic function of the operands will do.
    function automatic logic [199:0] opunit();
        logic [199:0] r;
        for (int i = 0; i < N_EL; i++) begin
            case (mop)
                3'd0:    r[i*8 +: 8] = ma[i] + mb[i];
                3'd1:    r[i*8 +: 8] = ma[i] - mb[i];
                default: r[i*8 +: 8] = ma[i] ^ mb[i];
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] w_load(input logic sel, input logic [4:0] idx, input logic [7:0] v);
        return {3'd1, sel, idx, 15'd0, v};
    endfunction

    function automatic logic [31:0] w_config(input logic [2:0] op, input logic [7:0] sz, input logic [7:0] f);
        return {3'd2, 10'd0, op, sz, f};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_EL; i++) begin
            ma[i] = 8'h00; mb[i] = 8'h00; mbuf[i] = 8'h00;
        end
        mop = 3'd0; msize = 8'd0; mfactor = 8'd0; merr = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_matrix_a"}, matrix_a, pack(ma));
        chk({tag, "_matrix_b"}, matrix_b, pack(mb));
        chk({tag, "_operation"}, 200'(operation), 200'(mop));
        chk({tag, "_size"}, 200'(size), 200'(msize));
        chk({tag, "_factor"}, 200'(factor), 200'(mfactor));
`ifdef MPU_CMD_ERROR_EN
        chk({tag, "_error"}, 200'(error), 200'(merr));
`endif
    endtask

    // Presents one word in IDLE for a single cycle and applies its effect to the model.
    task automatic send(input logic [31:0] w);
        chk("accept_ready", 200'(instr_ready), 200'(1'b1));
        instr       = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr       = $urandom;
        case (w[31:29])
            3'd0: if (w[0]) merr = 1'b0;
            3'd1: begin
                if (w[27:23] < 5'd25) begin
                    if (w[28]) mb[w[27:23]] = w[7:0];
                    else       ma[w[27:23]] = w[7:0];
                end else begin
                    merr = 1'b1;
                end
            end
            3'd2: begin
                mop = w[18:16]; msize = w[15:8]; mfactor = w[7:0];
            end
            3'd3, 3'd4: ;
            default: merr = 1'b1;
        endcase
    endtask

    // The correct result is only offered in the cycle before the capture edge.
    task automatic do_exec();
        logic [199:0] good;
        good = opunit();
        send({3'd3, 29'($urandom)});
        instr       = w_load(1'b0, 5'd1, 8'hAA);
        instr_valid = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            chk("exec_busy", 200'(busy), 200'(1'b1));
            chk("exec_ready", 200'(instr_ready), 200'(1'b0));
            result = (i == LAT - 1) ? good : rand200();
            tick();
        end
        instr_valid = 1'b0;
        result      = rand200();
        chk("exec_done_busy", 200'(busy), 200'(1'b0));
        chk("exec_done_ready", 200'(instr_ready), 200'(1'b1));
        for (int i = 0; i < N_EL; i++) mbuf[i] = good[i*8 +: 8];
        check_regs("exec");
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random. stop_at >= 0 abandons the stream.
    task automatic do_read(input int mode, input int stop_at);
        int n;
        int cyc;
        send({3'd4, 29'($urandom)});
        instr       = w_load(1'b1, 5'd2, 8'h5A);
        instr_valid = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < N_EL && cyc < 400) begin
            if (n == stop_at) break;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            chk("stream_valid", 200'(out_valid), 200'(1'b1));
            chk("stream_data", 200'(out_data), 200'(mbuf[n]));
            if (n == 0)        first_el = out_data;
            if (n == N_EL - 1) last_el  = out_data;
            tick();
            if (out_ready) n++;
            cyc++;
        end
        out_ready = 1'b0;
        if (stop_at < 0) begin
            instr_valid = 1'b0;
            chk("stream_count", 200'(n), 200'(N_EL));
            if (mode == 0) chk("stream_cycles", 200'(cyc), 200'(N_EL));
            chk("stream_end_valid", 200'(out_valid), 200'(1'b0));
            chk("stream_end_busy", 200'(busy), 200'(1'b0));
            chk("stream_end_ready", 200'(instr_ready), 200'(1'b1));
            check_regs("stream");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        instr       = 32'h0;
        instr_valid = 1'b0;
        out_ready   = 1'b0;
        result      = '0;
        model_reset();
        tick();
        tick();
        chk("rst_ready", 200'(instr_ready), 200'(1'b1));
        chk("rst_busy", 200'(busy), 200'(1'b0));
        chk("rst_valid", 200'(out_valid), 200'(1'b0));
        check_regs("rst");
        reset = 1'b0;
        tick();
        check_regs("post_rst");

        send(w_load(1'b0, 5'd0, 8'h05));
        send(w_load(1'b0, 5'd24, 8'hFD));
        send(w_load(1'b1, 5'd0, 8'h02));
        chk("dir_matrix_a", matrix_a, {8'hFD, 184'd0, 8'h05});
        chk("dir_matrix_b", matrix_b, {192'd0, 8'h02});
        check_regs("dir_load");

        send(w_config(3'd0, 8'd2, 8'd3));
        check_regs("dir_config");
        do_exec();
        do_read(0, -1);
        chk("dir_first", 200'(first_el), 200'(8'h07));
        chk("dir_last", 200'(last_el), 200'(8'hFD));
        do_read(1, -1);

        // Abandon a stream with reset while element 10 is on the bus.
        do_read(0, 10);
        instr_valid = 1'b0;
        reset       = 1'b1;
        tick();
        model_reset();
        chk("midrst_valid", 200'(out_valid), 200'(1'b0));
        chk("midrst_ready", 200'(instr_ready), 200'(1'b1));
        chk("midrst_busy", 200'(busy), 200'(1'b0));
        check_regs("midrst");
        reset = 1'b0;
        tick();
        do_read(2, -1);

        send(w_load(1'b0, 5'd25, 8'h55));
        check_regs("bad_idx_a");
        send(w_load(1'b1, 5'd31, 8'h66));
        check_regs("bad_idx_b");
        send({3'd7, 29'h1FFF_FFFF});
        check_regs("illegal7");
        send({3'd5, 29'($urandom)});
        check_regs("illegal5");
        send({3'd0, 29'h0000_0000});
        check_regs("nop_keep");
        send({3'd0, 29'h0000_0001});
        check_regs("nop_clear");

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    send(w_load(1'($urandom), 5'($urandom_range(0, 27)), 8'($urandom)));
                    check_regs("rnd_load");
                end
                4: begin
                    send(w_config(3'($urandom), 8'($urandom), 8'($urandom)));
                    check_regs("rnd_config");
                end
                5: begin
                    send({3'd0, 29'($urandom)});
                    check_regs("rnd_nop");
                end
                6: begin
                    send({3'($urandom_range(5, 7)), 29'($urandom)});
                    check_regs("rnd_illegal");
                end
                7: do_exec();
                8: do_read(2, -1);
                default: begin
                    instr_valid = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        instr = $urandom;
                        tick();
                    end
                    check_regs("rnd_idle");
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
